// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, slave FSM state type and lane helpers.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_t;

  // Little-endian byte-lane mask for a transfer of the given size.
  function automatic logic [3:0] be_decode(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE:  be_decode = 4'b0001 << a;
      HSIZE_HWORD: be_decode = 4'b0011 << {a[1], 1'b0};
      default:     be_decode = 4'b1111;
    endcase
  endfunction

  // Take enabled lanes from the newer data, the rest from the older word.
  function automatic logic [31:0] merge_lanes(input logic [3:0] be, input logic [31:0] newer,
                                              input logic [31:0] older);
    for (int i = 0; i < 4; i++)
      merge_lanes[8*i +: 8] = be[i] ? newer[8*i +: 8] : older[8*i +: 8];
  endfunction

endpackage

// File: rtl/riscv_ram_1rw_be.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables.
// A read cycle updates the output register; write cycles leave it unchanged.
module riscv_ram_1rw_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write or registered read of one word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
        for (int i = 0; i < 4; i++)
          if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/riscv_ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder: address/data pipeline, wait states, byte-lane
// writes, read-after-write forwarding and two-cycle ERROR response.
// A write whose data phase ends on the same edge a read is accepted cannot
// use the single RAM port, so it parks in a one-entry pending buffer and
// drains on the next edge with a free port; reads forward from either source.
module riscv_ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_SIZE    = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int AW = $clog2(MEM_SIZE / 4);

  slv_state_t    state;
  logic [3:0]    cnt;
  logic          dp_valid, dp_write;
  logic [AW-1:0] dp_addr;
  logic [3:0]    dp_be;
  logic          pend;
  logic [AW-1:0] pend_addr;
  logic [3:0]    pend_be;
  logic [31:0]   pend_data;
  logic [3:0]    fwd_be;
  logic [31:0]   fwd_data;
  logic [31:0]   rdata_hold;

  logic          addr_phase, addr_err, misaligned, acc_rd, commit, rd_phase;
  logic [AW-1:0] haddr_w;
  logic [3:0]    be;
  logic [AW-1:0] src_addr;
  logic [3:0]    src_be;
  logic [31:0]   src_data;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata, rd_merged;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

  assign addr_phase = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign misaligned = ((HSIZE == HSIZE_HWORD) & HADDR[0]) |
                      ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));
  assign addr_err   = (HADDR >= HADDR_SIZE'(MEM_SIZE)) | (HSIZE > HSIZE_WORD) | misaligned;
  assign acc_rd     = addr_phase & ~addr_err & ~HWRITE;
  assign commit     = dp_valid & dp_write & HREADYOUT & HREADY;
  assign rd_phase   = dp_valid & ~dp_write & HREADYOUT;
  assign haddr_w    = HADDR[AW+1:2];
  assign be         = be_decode(HSIZE, HADDR[1:0]);

  assign rd_merged  = merge_lanes(fwd_be, fwd_data, ram_rdata);
  assign HRDATA     = rd_phase ? rd_merged : rdata_hold;

  // Newest not-yet-in-RAM write that a read accepted this edge must see.
  always_comb begin
    src_addr = pend_addr;
    src_be   = pend ? pend_be : 4'b0000;
    src_data = pend_data;
    if (commit) begin
      src_addr = dp_addr;
      src_be   = dp_be;
      src_data = HWDATA;
    end
  end

  // RAM port arbitration: new read, then direct commit, then pending drain.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = pend_addr;
    ram_wdata = pend_data;
    if (!HRESET) begin
      if (acc_rd) begin
        ram_en   = 1'b1;
        ram_addr = haddr_w;
      end else if (commit) begin
        ram_en    = 1'b1;
        ram_we    = dp_be;
        ram_addr  = dp_addr;
        ram_wdata = HWDATA;
      end else if (pend) begin
        ram_en = 1'b1;
        ram_we = pend_be;
      end
    end
  end

  riscv_ram_1rw_be #(
    .DEPTH (MEM_SIZE / 4),
    .AW    (AW)
  ) u_ram (
    .clk   (HCLK),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Control: FSM, wait counter, data-phase valid, pending flag, read hold.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      HREADYOUT  <= 1'b1;
      HRESP      <= HRESP_OKAY;
      dp_valid   <= 1'b0;
      pend       <= 1'b0;
      rdata_hold <= '0;
    end else begin
      if (commit && acc_rd)       pend <= 1'b1;
      else if (!acc_rd && !commit) pend <= 1'b0;

      if (rd_phase) rdata_hold <= rd_merged;
      if (addr_phase && addr_err && !HWRITE) rdata_hold <= '0;

      if (HREADY) dp_valid <= addr_phase & ~addr_err;

      case (state)
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          if (addr_phase && addr_err) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end else if (addr_phase && (WAIT_STATES > 0)) begin
            state     <= ST_WAIT;
            cnt       <= 4'(WAIT_STATES - 1);
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_OKAY;
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Data: address-phase capture, forwarding snapshot, pending write contents.
  always_ff @(posedge HCLK) begin
    if (addr_phase) begin
      dp_write <= HWRITE;
      dp_addr  <= haddr_w;
      dp_be    <= be;
    end
    if (acc_rd) begin
      fwd_be   <= (src_addr == haddr_w) ? src_be : 4'b0000;
      fwd_data <= src_data;
    end
    if (commit && acc_rd) begin
      pend_addr <= dp_addr;
      pend_be   <= dp_be;
      pend_data <= HWDATA;
    end
  end

endmodule

// File: tb/tb_riscv_ahb3lite_sram_slave.sv
// Directed plus randomized bench for the AHB3-Lite SRAM responder, run on a
// zero-wait instance and a three-wait instance against a byte-array model.
module tb_riscv_ahb3lite_sram_slave;

  localparam int MEM = 256;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [1:0]  htrans    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  always #5 clk = ~clk;

  riscv_ahb3lite_sram_slave #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_SIZE(MEM), .WAIT_STATES(0)
  ) u_dut0 (
    .HCLK(clk), .HRESET(rst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
    .HRDATA(hrdata[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'b000),
    .HPROT(4'b0011), .HTRANS(htrans[0]), .HMASTLOCK(1'b0), .HREADY(hreadyout[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
  );

  riscv_ahb3lite_sram_slave #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_SIZE(MEM), .WAIT_STATES(3)
  ) u_dut3 (
    .HCLK(clk), .HRESET(rst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
    .HRDATA(hrdata[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'b000),
    .HPROT(4'b0011), .HTRANS(htrans[1]), .HMASTLOCK(1'b0), .HREADY(hreadyout[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
  );

  // Reference model state
  logic [7:0]  mem_m [2][MEM];
  int          ws_of [2];
  int          dp_kind [2];   // 0 none, 1 OK read, 2 OK write, 3 error
  logic        dp_wr   [2];
  logic [31:0] dp_exp  [2];
  logic [31:0] dp_addr [2];
  logic [2:0]  dp_size [2];
  logic [31:0] dp_wdata[2];
  logic [31:0] last_rd [2];
  int          last_waits [2];
  int          nvec = 0;
  int          nbad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    return (a >= 32'(MEM)) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
           (sz == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int b;
    b = int'(a & 32'hFFFF_FFFC);
    return {mem_m[d][b+3], mem_m[d][b+2], mem_m[d][b+1], mem_m[d][b]};
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
    int b;
    bit en;
    b = int'(a & 32'hFFFF_FFFC);
    for (int k = 0; k < 4; k++) begin
      if (sz == 3'd0)      en = (k == int'(a[1:0]));
      else if (sz == 3'd1) en = ((k / 2) == int'(a[1]));
      else                 en = 1'b1;
      if (en) mem_m[d][b+k] = wd[8*k +: 8];
    end
  endtask

  // Drive one address phase; finish and check the previous data phase.
  task automatic issue(input int d, input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int  waits;
    int  exp_w;
    bit  acc;
    hsel[d] = sel; htrans[d] = trans; hwrite[d] = wr; hsize[d] = size; haddr[d] = addr;
    hwdata[d] = dp_wdata[d];
    waits = 0;
    while (hreadyout[d] !== 1'b1 && waits < 40) begin
      check("hresp_during_wait", 32'(hresp[d]), (dp_kind[d] == 3) ? 32'd1 : 32'd0);
      waits++;
      @(negedge clk);
    end
    exp_w = (dp_kind[d] == 3) ? 1 : (dp_kind[d] != 0) ? ws_of[d] : 0;
    check("wait_cycles", 32'(waits), 32'(exp_w));
    last_waits[d] = waits;
    check("hresp_final", 32'(hresp[d]), (dp_kind[d] == 3) ? 32'd1 : 32'd0);
    if (dp_kind[d] == 1) begin
      check("read_data", hrdata[d], dp_exp[d]);
      last_rd[d] = hrdata[d];
    end
    if (dp_kind[d] == 3 && !dp_wr[d]) check("err_read_data", hrdata[d], 32'd0);
    if (dp_kind[d] == 2) model_write(d, dp_addr[d], dp_size[d], dp_wdata[d]);
    acc = sel && (trans == 2'b10 || trans == 2'b11);
    if (!acc)                   dp_kind[d] = 0;
    else if (is_err(addr, size)) dp_kind[d] = 3;
    else if (wr)                dp_kind[d] = 2;
    else                        dp_kind[d] = 1;
    dp_wr[d] = wr; dp_addr[d] = addr; dp_size[d] = size; dp_wdata[d] = wdata;
    dp_exp[d] = (dp_kind[d] == 1) ? model_word(d, addr) : 32'd0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int d);
    issue(d, 1'b0, 2'b00, 1'b0, 3'd2, 32'd0, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    int          r;
    ws_of[0] = 0; ws_of[1] = 3;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; hsel[d] = 1'b0; haddr[d] = '0; hwdata[d] = '0; hwrite[d] = 1'b0;
      hsize[d] = 3'd2; htrans[d] = 2'b00; dp_kind[d] = 0; dp_wdata[d] = '0; dp_wr[d] = 1'b0;
      last_rd[d] = '0; last_waits[d] = 0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("rst_hreadyout", 32'(hreadyout[d]), 32'd1);
      check("rst_hresp", 32'(hresp[d]), 32'd0);
      check("rst_hrdata", hrdata[d], 32'd0);
    end

    // Fill every word so later reads are fully defined
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < MEM / 4; i++)
        issue(d, 1'b1, 2'b10, 1'b1, 3'd2, 32'(i * 4), $urandom());
      idle(d);
    end

    // Zero-wait: back-to-back write then read of the same word
    issue(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'd0);
    idle(0);
    check("fwd_word", last_rd[0], 32'hDEADBEEF);
    check("fwd_waits", 32'(last_waits[0]), 32'd0);

    // Byte and halfword lane writes merged into one word
    issue(0, 1'b1, 2'b10, 1'b1, 3'd0, 32'h20, 32'h0000_0011);
    issue(0, 1'b1, 2'b11, 1'b1, 3'd0, 32'h21, 32'h0000_2200);
    issue(0, 1'b1, 2'b11, 1'b1, 3'd1, 32'h22, 32'h4433_0000);
    issue(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'd0);
    idle(0);
    check("lane_merge", last_rd[0], 32'h4433_2211);

    // Error responses, then a valid halfword write into the errored word
    for (int d = 0; d < 2; d++) begin
      issue(d, 1'b1, 2'b10, 1'b1, 3'd2, 32'h0, 32'h1234_5678);
      issue(d, 1'b1, 2'b10, 1'b0, 3'd2, 32'(MEM), 32'd0);
      issue(d, 1'b1, 2'b10, 1'b0, 3'd2, 32'h2, 32'd0);
      issue(d, 1'b1, 2'b10, 1'b1, 3'd1, 32'h2, 32'h0055_0000);
      issue(d, 1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'd0);
      idle(d);
      check("err_then_hword", last_rd[d], 32'h0055_5678);
    end

    // BUSY, IDLE and deselected transfers leave memory alone
    issue(0, 1'b1, 2'b01, 1'b1, 3'd2, 32'h10, 32'h1111_1111);
    issue(0, 1'b1, 2'b00, 1'b1, 3'd2, 32'h10, 32'h2222_2222);
    issue(0, 1'b0, 2'b10, 1'b1, 3'd2, 32'h10, 32'h3333_3333);
    issue(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'd0);
    idle(0);
    check("no_write_idle_busy", last_rd[0], 32'hDEADBEEF);

    // Three wait states on a single read
    issue(1, 1'b1, 2'b10, 1'b0, 3'd2, 32'h0, 32'd0);
    idle(1);
    check("ws3_waits", 32'(last_waits[1]), 32'd3);
    check("ws3_data", last_rd[1], 32'h0055_5678);

    // Reset in the middle of a waited write drops the write
    issue(1, 1'b1, 2'b10, 1'b1, 3'd2, 32'h40, 32'hA5A5_0001);
    idle(1);
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; hsize[1] = 3'd2; haddr[1] = 32'h40;
    @(posedge clk);
    @(negedge clk);
    check("wait_before_reset", 32'(hreadyout[1]), 32'd0);
    htrans[1] = 2'b00; hwdata[1] = 32'hFFFF_FFFF; rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    check("mid_rst_hreadyout", 32'(hreadyout[1]), 32'd1);
    check("mid_rst_hresp", 32'(hresp[1]), 32'd0);
    check("mid_rst_hrdata", hrdata[1], 32'd0);
    dp_kind[1] = 0; dp_wdata[1] = '0;
    issue(1, 1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'd0);
    idle(1);
    check("dropped_write", last_rd[1], 32'hA5A5_0001);

    // Randomized traffic against the model
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 7);
        trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r % 2 == 0) ? 2'b10 : 2'b11;
        r = $urandom_range(0, 7);
        size = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 7) ? 3'd2 : 3'($urandom_range(3, 7));
        if ($urandom_range(0, 15) == 0) addr = 32'(MEM + $urandom_range(0, 63));
        else begin
          addr = 32'($urandom_range(0, MEM - 1));
          if ($urandom_range(0, 3) != 0 && size <= 3'd2)
            addr = addr & ~((32'd1 << size) - 32'd1);
        end
        issue(d, ($urandom_range(0, 7) != 0), trans, 1'($urandom_range(0, 1)), size, addr,
              $urandom());
      end
      idle(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
